// File: rtl/tetris_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_cmd_pkg (package)
// Purpose  : Shared definitions for the tetris command scheduler: command
//            width, command codes and the source index used for the
//            pending-flag vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tetris_cmd_pkg;

  localparam int CMD_W   = 3;
  localparam int NUM_SRC = 6;

  // Command codes; 0 and 7 are never emitted
  localparam logic [CMD_W-1:0] CMD_NONE  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_ROT   = 3'd1;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_SOFT  = 3'd4;
  localparam logic [CMD_W-1:0] CMD_HARD  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_GRAV  = 3'd6;

  // Bit positions in the pending-flag vector
  typedef enum logic [2:0] {
    SRC_ROT   = 3'd0,
    SRC_RIGHT = 3'd1,
    SRC_LEFT  = 3'd2,
    SRC_SOFT  = 3'd3,
    SRC_HARD  = 3'd4,
    SRC_GRAV  = 3'd5
  } src_e;

endpackage
`default_nettype wire

// File: rtl/tetris_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tetris_cmd_scheduler_if
// Purpose  : Valid/ready command stream from the scheduler to game logic.
// Ports    : cmd_valid (head valid), cmd_code (head command),
//            cmd_ready (consumer accepts head).
//            master = scheduler side, slave = game-logic side.
// Revision : 1.0 - initial release
// ============================================================================
interface tetris_cmd_scheduler_if;
  import tetris_cmd_pkg::*;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_code;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Small synchronous FIFO with occupancy count. A push while full
//            is ignored even if a pop happens in the same cycle; a pop while
//            empty is ignored. pop_data reads 0 when empty.
// Ports    : clk, rst_n (async, active-low), push/push_data, pop/pop_data,
//            count, full, empty.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         pop_data,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  // Storage is not reset: the empty gate on pop_data hides stale entries
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers are exactly c_aw bits, so they wrap modulo DEPTH naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tetris_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tetris_cmd_scheduler
// Purpose  : Merges five button pulses and a gravity tick into one ordered
//            command stream: one pending flag per source, fixed-priority
//            arbiter (HARD > ROT > LEFT > RIGHT > SOFT > GRAV) pushing into
//            a FIFO drained over a valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            pls_c/e/w/s/n   one-cycle button pulses
//            held_e/w/s      button levels (auto-repeat only)
//            run             game active; gates gravity and capture
//            cmd_if          master side of the command stream
//            drop_cnt        saturating count of merged events
// Config   : `define TETRIS_AUTO_REPEAT_EN adds DAS auto-repeat on E/W/S.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_cmd_scheduler
  import tetris_cmd_pkg::*;
#(
  parameter int unsigned GRAVITY_DIV = 50000000,
  parameter int unsigned DAS_DELAY   = 8000000,
  parameter int unsigned DAS_RATE    = 2000000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   pls_c,
  input  wire logic                   pls_e,
  input  wire logic                   pls_w,
  input  wire logic                   pls_s,
  input  wire logic                   pls_n,
  input  wire logic                   held_e,
  input  wire logic                   held_w,
  input  wire logic                   held_s,
  input  wire logic                   run,
  tetris_cmd_scheduler_if.master      cmd_if,
  output logic [7:0]                  drop_cnt
);

  localparam int c_gw = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;
  localparam logic [c_gw-1:0] c_grav_last = c_gw'(GRAVITY_DIV - 1);

  logic [NUM_SRC-1:0]      r_flag;
  logic [NUM_SRC-1:0]      w_evt;
  logic [NUM_SRC-1:0]      w_grant;
  logic [NUM_SRC-1:0]      w_drop;
  logic [2:0]              w_drop_num;
  logic [8:0]              w_drop_sum;
  logic [7:0]              r_drop_cnt;
  logic [c_gw-1:0]         r_grav_cnt;
  logic                    w_tick;
  logic [2:0]              w_rep;       // {S, W, E} auto-repeat events
  logic [CMD_W-1:0]        w_push_code;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;
  logic [CMD_W-1:0]        w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count_unused;

  // ---------------------------------------------------------------- repeat
`ifdef TETRIS_AUTO_REPEAT_EN
  logic [2:0] w_held;
  assign w_held = {held_s, held_w, held_e};

  for (genvar g = 0; g < 3; g++) begin : g_rep
    logic [31:0] r_cnt;
    logic        r_armed;   // first repeat done; later ones use DAS_RATE
    logic [31:0] w_limit;

    assign w_limit  = r_armed ? 32'(DAS_RATE - 1) : 32'(DAS_DELAY - 1);
    assign w_rep[g] = run & w_held[g] & (r_cnt == w_limit);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
      end else if (!run || !w_held[g]) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
      end else if (r_cnt == w_limit) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic w_held_unused;
  localparam int unsigned c_das_unused = DAS_DELAY + DAS_RATE;
  assign w_held_unused = held_e ^ held_w ^ held_s;
  assign w_rep         = '0;
`endif

  // --------------------------------------------------------------- gravity
  assign w_tick = run & (r_grav_cnt == c_grav_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grav_cnt <= '0;
    end else if (!run || w_tick || w_grant[SRC_SOFT] || w_grant[SRC_HARD]) begin
      r_grav_cnt <= '0;
    end else begin
      r_grav_cnt <= r_grav_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- events
  always_comb begin
    w_evt            = '0;
    w_evt[SRC_ROT]   = pls_c;
    w_evt[SRC_RIGHT] = pls_e | w_rep[0];
    w_evt[SRC_LEFT]  = pls_w | w_rep[1];
    w_evt[SRC_SOFT]  = pls_s | w_rep[2];
    w_evt[SRC_HARD]  = pls_n;
    w_evt[SRC_GRAV]  = w_tick;
  end

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    w_grant     = '0;
    w_push_code = CMD_NONE;
    if (run && !w_full) begin
      if (r_flag[SRC_HARD]) begin
        w_grant[SRC_HARD] = 1'b1;  w_push_code = CMD_HARD;
      end else if (r_flag[SRC_ROT]) begin
        w_grant[SRC_ROT] = 1'b1;   w_push_code = CMD_ROT;
      end else if (r_flag[SRC_LEFT]) begin
        w_grant[SRC_LEFT] = 1'b1;  w_push_code = CMD_LEFT;
      end else if (r_flag[SRC_RIGHT]) begin
        w_grant[SRC_RIGHT] = 1'b1; w_push_code = CMD_RIGHT;
      end else if (r_flag[SRC_SOFT]) begin
        w_grant[SRC_SOFT] = 1'b1;  w_push_code = CMD_SOFT;
      end else if (r_flag[SRC_GRAV]) begin
        w_grant[SRC_GRAV] = 1'b1;  w_push_code = CMD_GRAV;
      end
    end
  end

  assign w_push = |w_grant;

  // An event on a flag that is set and not leaving this cycle is merged
  assign w_drop = run ? (w_evt & r_flag & ~w_grant) : '0;

  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_drop_num = w_drop_num + {2'b00, w_drop[i]};
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {6'b0, w_drop_num};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag     <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_flag     <= run ? ((r_flag & ~w_grant) | w_evt) : '0;
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign drop_cnt = r_drop_cnt;

  // ------------------------------------------------------------------- fifo
  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_code),
    .pop       (cmd_if.cmd_ready),
    .pop_data  (w_head),
    .count     (w_count_unused),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign cmd_if.cmd_valid = ~w_empty;
  assign cmd_if.cmd_code  = w_head;

endmodule
`default_nettype wire

// File: tb/tb_tetris_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_cmd_scheduler
// Purpose  : Self-checking bench for tetris_cmd_scheduler with
//            GRAVITY_DIV=16, DAS_DELAY=8, DAS_RATE=4, FIFO_DEPTH=4.
//            A per-cycle vector table covers ordering, latency, merging and
//            run gating; hand-written sequences cover FIFO stall, gravity
//            restart, drain after run drop, async reset and auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_cmd_scheduler;

  localparam logic [4:0] P_C = 5'b00001;
  localparam logic [4:0] P_E = 5'b00010;
  localparam logic [4:0] P_W = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_N = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pls_c = 1'b0, pls_e = 1'b0, pls_w = 1'b0, pls_s = 1'b0, pls_n = 1'b0;
  logic held_e = 1'b0, held_w = 1'b0, held_s = 1'b0;
  logic run = 1'b0;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  tetris_cmd_scheduler_if u_if ();

  tetris_cmd_scheduler #(
    .GRAVITY_DIV (16),
    .DAS_DELAY   (8),
    .DAS_RATE    (4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pls_c    (pls_c),
    .pls_e    (pls_e),
    .pls_w    (pls_w),
    .pls_s    (pls_s),
    .pls_n    (pls_n),
    .held_e   (held_e),
    .held_w   (held_w),
    .held_s   (held_s),
    .run      (run),
    .cmd_if   (u_if),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pls;
    logic       run;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t tbl [27];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pls(input logic [4:0] p);
    {pls_n, pls_s, pls_w, pls_e, pls_c} = p;
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    run = 1'b0;
    set_pls('0);
    {held_e, held_w, held_s} = '0;
    u_if.cmd_ready = ready;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_row(input int i, input logic [4:0] p, input logic r,
                         input logic v, input logic [2:0] c, input logic [7:0] d);
    tbl[i].pls = p;  tbl[i].run = r;  tbl[i].exp_valid = v;
    tbl[i].exp_code = c;  tbl[i].exp_drop = d;
  endtask

  initial begin
    int first;
    int seen;

    // Rows indexed by edge-1 after run goes high. A HARD grant at edge 13
    // restarts gravity, so no GRAV tick lands inside this table.
    for (int i = 0; i < 9; i++) set_row(i, '0, 1'b1, 1'b0, 3'd0, 8'd0);
    set_row( 9, P_W,             1'b1, 1'b0, 3'd0, 8'd0); // e10 pulse
    set_row(10, '0,              1'b1, 1'b1, 3'd3, 8'd0); // e11 LEFT
    set_row(11, P_C | P_N | P_E, 1'b1, 1'b0, 3'd0, 8'd0); // e12 LEFT popped
    set_row(12, '0,              1'b1, 1'b1, 3'd5, 8'd0); // HARD first
    set_row(13, '0,              1'b1, 1'b1, 3'd1, 8'd0); // then ROT
    set_row(14, '0,              1'b1, 1'b1, 3'd2, 8'd0); // then RIGHT
    set_row(15, '0,              1'b1, 1'b0, 3'd0, 8'd0);
    set_row(16, '0,              1'b1, 1'b0, 3'd0, 8'd0);
    set_row(17, P_S,             1'b1, 1'b0, 3'd0, 8'd0); // e18 SOFT flag
    set_row(18, P_S,             1'b1, 1'b1, 3'd4, 8'd0); // pulse in grant cycle
    set_row(19, '0,              1'b1, 1'b1, 3'd4, 8'd0); // second SOFT, no drop
    set_row(20, '0,              1'b1, 1'b0, 3'd0, 8'd0);
    set_row(21, P_N | P_S,       1'b1, 1'b0, 3'd0, 8'd0);
    set_row(22, P_S,             1'b1, 1'b1, 3'd5, 8'd1); // SOFT blocked: merge
    set_row(23, '0,              1'b1, 1'b1, 3'd4, 8'd1);
    set_row(24, '0,              1'b1, 1'b0, 3'd0, 8'd1);
    set_row(25, P_C,             1'b0, 1'b0, 3'd0, 8'd1); // run=0 ignores
    set_row(26, P_C | P_W,       1'b0, 1'b0, 3'd0, 8'd1);

    // ---------------- reset state
    u_if.cmd_ready = 1'b1;
    #2;
    check("reset_valid", int'(u_if.cmd_valid), 0);
    check("reset_code",  int'(u_if.cmd_code),  0);
    check("reset_drop",  int'(drop_cnt),       0);

    // ---------------- table-driven sequence
    do_reset(1'b1);
    for (int i = 0; i < 27; i++) begin
      set_pls(tbl[i].pls);
      run = tbl[i].run;
      step();
      check($sformatf("tbl%0d_valid", i), int'(u_if.cmd_valid), int'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_code", i),  int'(u_if.cmd_code),  int'(tbl[i].exp_code));
      check($sformatf("tbl%0d_drop", i),  int'(drop_cnt),       int'(tbl[i].exp_drop));
    end
    set_pls('0);

    // ---------------- stall: ticks at edges 16,32,...; FIFO full after 65,
    // fifth GRAV pending from 80, merged at 96
    do_reset(1'b0);
    run = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 16) check("stall_e16_valid", int'(u_if.cmd_valid), 0);
      if (k == 17) check("stall_e17_code", int'(u_if.cmd_code), 6);
      if (k == 80) check("stall_e80_drop", int'(drop_cnt), 0);
      if (k == 95) check("stall_e95_drop", int'(drop_cnt), 0);
      if (k == 96) check("stall_e96_drop", int'(drop_cnt), 1);
    end
    check("stall_hold_valid", int'(u_if.cmd_valid), 1);
    check("stall_hold_code",  int'(u_if.cmd_code),  6);
    u_if.cmd_ready = 1'b1;
    seen = 0;
    for (int k = 100; k < 110; k++) begin
      if (u_if.cmd_valid && u_if.cmd_code == 3'd6) seen++;
      step();
    end
    check("stall_grav_count", seen, 5);
    check("stall_final_drop", int'(drop_cnt), 1);

    // ---------------- SOFT at gravity count 10 restarts the period:
    // grant at e12, tick at e28, GRAV visible after e29
    do_reset(1'b1);
    run = 1'b1;
    for (int k = 1; k <= 10; k++) step();
    set_pls(P_S);
    step();                                   // e11
    set_pls('0);
    step();                                   // e12
    check("soft_valid", int'(u_if.cmd_valid), 1);
    check("soft_code",  int'(u_if.cmd_code),  4);
    first = 0;
    for (int k = 13; k <= 40; k++) begin
      step();
      if (k == 17) check("soft_no_old_tick", int'(u_if.cmd_valid), 0);
      if (first == 0 && u_if.cmd_valid && u_if.cmd_code == 3'd6) first = k;
    end
    check("soft_next_grav_edge", first, 29);

    // ---------------- run drop with 2 entries queued and LEFT pending
    do_reset(1'b0);
    run = 1'b1;
    step();                                   // e1
    set_pls(P_N | P_C | P_W);
    step();                                   // e2 flags set
    set_pls('0);
    step();                                   // e3 push HARD
    step();                                   // e4 push ROT
    run = 1'b0;
    set_pls(P_E);
    step();                                   // e5 flags cleared
    set_pls('0);
    step();                                   // e6
    check("drain_head0", int'(u_if.cmd_code), 5);
    u_if.cmd_ready = 1'b1;
    step();                                   // e7 pop HARD
    check("drain_head1", int'(u_if.cmd_code), 1);
    step();                                   // e8 pop ROT
    seen = 0;
    for (int k = 8; k <= 12; k++) begin
      if (u_if.cmd_valid) seen++;
      step();
    end
    check("drain_no_new", seen, 0);
    check("drain_drop", int'(drop_cnt), 0);

    // ---------------- async reset mid-drain
    run = 1'b1;
    u_if.cmd_ready = 1'b0;
    set_pls(P_N | P_C);
    step();
    set_pls('0);
    step();
    step();
    check("prereset_valid", int'(u_if.cmd_valid), 1);
    u_if.cmd_ready = 1'b1;
    step();
    check("prereset_code", int'(u_if.cmd_code), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(u_if.cmd_valid), 0);
    check("async_rst_code",  int'(u_if.cmd_code),  0);
    check("async_rst_drop",  int'(drop_cnt),       0);

    // ---------------- auto-repeat: held_e for 20 edges
    do_reset(1'b1);
    run = 1'b1;
    held_e = 1'b1;
    seen = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 21) held_e = 1'b0;
      step();
      if (u_if.cmd_valid && u_if.cmd_code == 3'd2) seen++;
    end
`ifdef TETRIS_AUTO_REPEAT_EN
    check("repeat_right_count", seen, 4);
`else
    check("repeat_right_count", seen, 0);
`endif
    check("repeat_drop", int'(drop_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/tetris_cmd_scheduler.md
Name: tetris_cmd_scheduler

Overview:
- Sits between the button edge detector pulses and the tetris game-state logic.
- Turns five one-cycle button pulses and an internal gravity tick into a single ordered command stream.
- Arbitrates by fixed priority and buffers commands in a small FIFO.
- Delivers commands over a valid/ready handshake, so game logic can stall without losing inputs.

Parameters:
- GRAVITY_DIV, 50000000: clk cycles per gravity tick.
- DAS_DELAY, 8000000: hold cycles before first auto-repeat (AUTO_REPEAT_EN only).
- DAS_RATE, 2000000: cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).
- FIFO_DEPTH, 4: command FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pls_c  in  1  rotate pulse.
- pls_e  in  1  right pulse.
- pls_w  in  1  left pulse.
- pls_s  in  1  soft-drop pulse.
- pls_n  in  1  hard-drop pulse.
- held_e  in  1  synchronized right-button level.
- held_w  in  1  synchronized left-button level.
- held_s  in  1  synchronized soft-drop level.
- run  in  1  game active; gates gravity and event capture.
- cmd_valid  out  1  FIFO head valid.
- cmd_code  out  3  FIFO head command.
- cmd_ready  in  1  consumer accepts head.
- drop_cnt  out  8  saturating count of merged/lost events.

Behaviour:
- Command codes:
  - ROT=1, RIGHT=2, LEFT=3, SOFT=4, HARD=5, GRAV=6.
  - 0 and 7 are never emitted.
- Reset values:
  - All pending flags 0; gravity counter 0; FIFO empty.
  - cmd_valid=0, cmd_code=0, drop_cnt=0.
- Pending flags (one per source, registered):
  - A pulse with run=1 sets its flag at the next edge.
  - If the flag is already set and not being granted that cycle, the event merges and drop_cnt increments (saturates at 255).
- Arbiter:
  - Combinational over the flags.
  - Priority HARD > ROT > LEFT > RIGHT > SOFT > GRAV.
  - At most one grant per cycle, and only when FIFO count < FIFO_DEPTH.
  - The grant pushes the code and clears that flag.
  - A new pulse on the same source in the grant cycle leaves the flag set; it counts as a new event, not a drop.
- Latency: pulse sampled at edge N → flag set at N → pushed at edge N+1 → cmd_valid=1 after N+1 if the FIFO was empty and no higher-priority flag is pending.
- FIFO:
  - cmd_valid = not empty; cmd_code = head entry, held stable while cmd_valid=1 and cmd_ready=0.
  - Pop on cmd_valid & cmd_ready.
  - Push and pop in the same cycle are both legal when 0 < count < DEPTH; count is unchanged.
  - When full, no push occurs even if a pop happens that cycle. Flags stay pending, with no loss.
  - Pointers wrap modulo FIFO_DEPTH.
- Gravity:
  - Counter increments while run=1.
  - At GRAVITY_DIV-1 it wraps to 0 and sets the GRAV flag.
  - A SOFT or HARD grant resets the counter to 0.
  - run=0 holds the counter at 0.
- run=0:
  - All flags cleared; pulses ignored and not counted in drop_cnt.
  - FIFO continues to drain normally.
- Asynchronous reset mid-operation discards FIFO contents and flags immediately.

Optional Feature:
- Macro: TETRIS_AUTO_REPEAT_EN.
- Defined:
  - Each of E/W/S has a repeat counter, cleared while its held_* is 0 or run=0.
  - The first repeat sets the flag after DAS_DELAY consecutive held cycles; later repeats follow every DAS_RATE cycles while held.
  - A repeat on an already-pending flag merges and increments drop_cnt.
- Undefined:
  - held_* ports remain but are ignored.
  - No repeat counters are synthesized.

Decomposition:
- Package tetris_cmd_pkg:
  - CMD_W=3.
  - Command code constants ROT/RIGHT/LEFT/SOFT/HARD/GRAV.
  - Source index enum for the flag vector.
- Sub-module cmd_fifo: parameterized synchronous FIFO (width CMD_W, depth FIFO_DEPTH) with count, full and empty.

Test Plan (GRAVITY_DIV=16, DAS_DELAY=8, DAS_RATE=4, FIFO_DEPTH=4, cmd_ready=1 unless stated):
- Single pls_w at cycle 10 → cmd_valid=1, cmd_code=3 from cycle 12 for exactly one cycle.
- pls_c, pls_n, pls_e in the same cycle → codes emitted 5, 1, 2 on consecutive cycles.
- cmd_ready=0, run=1 for 100 cycles → FIFO holds GRAV ×4, then a fifth GRAV stays pending; the next tick merges and drop_cnt=1. Raising ready yields five GRAV codes.
- pls_s at gravity count 10 → SOFT emitted; the next GRAV comes 16 cycles after the SOFT grant, not at count 15.
- run dropped with flags pending and FIFO holding 2 entries → those 2 entries drain, no new codes, drop_cnt unchanged; asserting rst_n=0 mid-drain forces cmd_valid=0 at once.
- With TETRIS_AUTO_REPEAT_EN, held_e high for 20 cycles → RIGHT codes from hold cycles 8, 12, 16, 20 (4 total). Without the macro → none.
